// File: rtl/sdram_init_seq.sv
// SDRAM power-up sequencer: waits for PLL lock, holds the power-up NOP delay, then issues
// PRECHARGE ALL, REFRESH_CNT x AUTO REFRESH and LOAD MODE before raising init_done.
module sdram_init_seq #(
  parameter int POWERUP_CYC = 28600,
  parameter int TRP_CYC     = 3,
  parameter int TRFC_CYC    = 9,
  parameter int TMRD_CYC    = 2,
  parameter int REFRESH_CNT = 8,
  parameter int ADDR_W      = 13,
  parameter int BA_W        = 2,
  parameter logic [ADDR_W-1:0] MODE_REG = ADDR_W'(13'h0030)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              restart,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BA_W-1:0]   sdram_ba,
  output logic              init_done,
  output logic              busy
);

  localparam int MAX_0 = (POWERUP_CYC > TRP_CYC)  ? POWERUP_CYC : TRP_CYC;
  localparam int MAX_1 = (MAX_0 > TRFC_CYC)       ? MAX_0       : TRFC_CYC;
  localparam int MAX_2 = (MAX_1 > TMRD_CYC)       ? MAX_1       : TMRD_CYC;
  localparam int MAX_3 = (MAX_2 > REFRESH_CNT)    ? MAX_2       : REFRESH_CNT;
  localparam int CNT_W = $clog2(MAX_3 + 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] PWR_LD  = CNT_W'(POWERUP_CYC);
  localparam logic [CNT_W-1:0] TRP_LD  = CNT_W'(TRP_CYC - 1);
  localparam logic [CNT_W-1:0] TRFC_LD = CNT_W'(TRFC_CYC - 1);
  localparam logic [CNT_W-1:0] TMRD_LD = CNT_W'(TMRD_CYC - 1);
  localparam logic [CNT_W-1:0] REF_N   = CNT_W'(REFRESH_CNT);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  localparam logic [ADDR_W-1:0] ADDR_A10 = ADDR_W'(11'h400);

  typedef enum logic [3:0] {
    S_WAIT_LOCK,
    S_POWERUP,
    S_PRECHARGE,
    S_WAIT_TRP,
    S_REFRESH,
    S_WAIT_TRFC,
    S_LOAD_MODE,
    S_WAIT_TMRD,
    S_DONE
  } state_t;

  state_t           state;
  logic [1:0]       lock_sync;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ref_cnt;

  assign lock_s = lock_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync <= 2'b00;
    end else begin
      lock_sync <= {lock_sync[0], pll_locked};
    end
  end

  // Outputs reflect the state being entered, so a command appears on the same
  // edge that moves the FSM into its command state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT_LOCK;
      sdram_cke  <= 1'b0;
      sdram_cmd  <= CMD_NOP;
      sdram_addr <= '0;
      sdram_ba   <= '0;
      init_done  <= 1'b0;
      busy       <= 1'b1;
      cnt        <= '0;
      ref_cnt    <= '0;
    end else begin
      sdram_cmd  <= CMD_NOP;
      sdram_addr <= '0;
      sdram_ba   <= '0;

      if (state != S_WAIT_LOCK && !lock_s) begin
        state     <= S_WAIT_LOCK;
        sdram_cke <= 1'b0;
        init_done <= 1'b0;
        busy      <= 1'b1;
        cnt       <= '0;
        ref_cnt   <= '0;
      end else if (state != S_WAIT_LOCK && restart) begin
        state     <= S_POWERUP;
        sdram_cke <= 1'b1;
        init_done <= 1'b0;
        busy      <= 1'b1;
        cnt       <= PWR_LD;
        ref_cnt   <= '0;
      end else begin
        case (state)
          S_WAIT_LOCK: begin
            sdram_cke <= 1'b0;
            init_done <= 1'b0;
            busy      <= 1'b1;
            if (lock_s) begin
              state     <= S_POWERUP;
              sdram_cke <= 1'b1;
              cnt       <= PWR_LD;
              ref_cnt   <= '0;
            end
          end

          S_POWERUP: begin
            if (cnt == CNT_ONE) begin
              state      <= S_PRECHARGE;
              sdram_cmd  <= CMD_PRE;
              sdram_addr <= ADDR_A10;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end

          S_PRECHARGE: begin
            if (TRP_CYC == 1) begin
              state     <= S_REFRESH;
              sdram_cmd <= CMD_REF;
              ref_cnt   <= ref_cnt + CNT_ONE;
            end else begin
              state <= S_WAIT_TRP;
              cnt   <= TRP_LD;
            end
          end

          S_WAIT_TRP: begin
            if (cnt == CNT_ONE) begin
              state     <= S_REFRESH;
              sdram_cmd <= CMD_REF;
              ref_cnt   <= ref_cnt + CNT_ONE;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end

          S_REFRESH: begin
            if (TRFC_CYC != 1) begin
              state <= S_WAIT_TRFC;
              cnt   <= TRFC_LD;
            end else if (ref_cnt == REF_N) begin
              state      <= S_LOAD_MODE;
              sdram_cmd  <= CMD_LMR;
              sdram_addr <= MODE_REG;
            end else begin
              sdram_cmd <= CMD_REF;
              ref_cnt   <= ref_cnt + CNT_ONE;
            end
          end

          S_WAIT_TRFC: begin
            if (cnt != CNT_ONE) begin
              cnt <= cnt - CNT_ONE;
            end else if (ref_cnt == REF_N) begin
              state      <= S_LOAD_MODE;
              sdram_cmd  <= CMD_LMR;
              sdram_addr <= MODE_REG;
            end else begin
              state     <= S_REFRESH;
              sdram_cmd <= CMD_REF;
              ref_cnt   <= ref_cnt + CNT_ONE;
            end
          end

          S_LOAD_MODE: begin
            if (TMRD_CYC == 1) begin
              state     <= S_DONE;
              init_done <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state <= S_WAIT_TMRD;
              cnt   <= TMRD_LD;
            end
          end

          S_WAIT_TMRD: begin
            if (cnt == CNT_ONE) begin
              state     <= S_DONE;
              init_done <= 1'b1;
              busy      <= 1'b0;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end

          S_DONE: begin
            sdram_cke <= 1'b1;
            init_done <= 1'b1;
            busy      <= 1'b0;
          end

          default: begin
            state <= S_WAIT_LOCK;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: two instances (nominal timing and all-minimum timing) checked
// cycle by cycle against a command-schedule model derived from the timing parameters.
module tb_sdram_init_seq;

  localparam int AP = 20, ATRP = 3, ATRFC = 4, ATMRD = 2, AR = 2;
  localparam int BP = 3, BT = 1, BR = 1;
  localparam logic [12:0] MODE = 13'h0030;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pll_a = 1'b0, restart_a = 1'b0;
  logic        pll_b = 1'b0, restart_b = 1'b0;
  logic        cke_a, cke_b, done_a, done_b, busy_a, busy_b;
  logic [3:0]  cmd_a, cmd_b;
  logic [12:0] addr_a, addr_b;
  logic [1:0]  ba_a, ba_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdram_init_seq #(.POWERUP_CYC(AP), .TRP_CYC(ATRP), .TRFC_CYC(ATRFC), .TMRD_CYC(ATMRD),
                   .REFRESH_CNT(AR), .MODE_REG(MODE), .ADDR_W(13), .BA_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_a), .restart(restart_a),
    .sdram_cke(cke_a), .sdram_cmd(cmd_a), .sdram_addr(addr_a), .sdram_ba(ba_a),
    .init_done(done_a), .busy(busy_a));

  sdram_init_seq #(.POWERUP_CYC(BP), .TRP_CYC(BT), .TRFC_CYC(BT), .TMRD_CYC(BT),
                   .REFRESH_CNT(BR), .MODE_REG(MODE), .ADDR_W(13), .BA_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_b), .restart(restart_b),
    .sdram_cke(cke_b), .sdram_cmd(cmd_b), .sdram_addr(addr_b), .sdram_ba(ba_b),
    .init_done(done_b), .busy(busy_b));

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // Expected bus contents k cycles after POWERUP entry, from the command schedule.
  function automatic void model(input int p, input int trp, input int trfc, input int tmrd,
                                input int r, input int k, output logic [3:0] cmd,
                                output logic [12:0] addr, output logic [1:0] ba,
                                output logic done);
    int t_lmr;
    cmd  = 4'b0111;
    addr = 13'h0;
    ba   = 2'b00;
    if (k == p) begin
      cmd  = 4'b0010;
      addr = 13'h400;
    end
    for (int i = 0; i < r; i++)
      if (k == p + trp + i * trfc) cmd = 4'b0001;
    t_lmr = p + trp + r * trfc;
    if (k == t_lmr) begin
      cmd  = 4'b0000;
      addr = MODE;
    end
    done = (k >= t_lmr + tmrd);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic obs(input bit b, output logic c, output logic [3:0] cm, output logic [12:0] ad,
                     output logic [1:0] bb, output logic d, output logic bs);
    if (b) begin
      c = cke_b; cm = cmd_b; ad = addr_b; bb = ba_b; d = done_b; bs = busy_b;
    end else begin
      c = cke_a; cm = cmd_a; ad = addr_a; bb = ba_a; d = done_a; bs = busy_a;
    end
  endtask

  task automatic check_idle(input bit b, input string tag);
    logic c, d, bs;
    logic [3:0] cm;
    logic [12:0] ad;
    logic [1:0] bb;
    obs(b, c, cm, ad, bb, d, bs);
    chk({tag, "_cke"}, 32'(c), 32'(0));
    chk({tag, "_cmd"}, 32'(cm), 32'(4'b0111));
    chk({tag, "_addr"}, 32'(ad), 32'(0));
    chk({tag, "_ba"}, 32'(bb), 32'(0));
    chk({tag, "_init_done"}, 32'(d), 32'(0));
    chk({tag, "_busy"}, 32'(bs), 32'(1));
  endtask

  task automatic check_k(input bit b, input int k, output bit is_cmd);
    logic c, d, bs, ed;
    logic [3:0] cm, ecm;
    logic [12:0] ad, ead;
    logic [1:0] bb, eba;
    obs(b, c, cm, ad, bb, d, bs);
    if (b) model(BP, BT, BT, BT, BR, k, ecm, ead, eba, ed);
    else   model(AP, ATRP, ATRFC, ATMRD, AR, k, ecm, ead, eba, ed);
    chk($sformatf("cke@%0d", k), 32'(c), 32'(1));
    chk($sformatf("cmd@%0d", k), 32'(cm), 32'(ecm));
    chk($sformatf("addr@%0d", k), 32'(ad), 32'(ead));
    chk($sformatf("ba@%0d", k), 32'(bb), 32'(eba));
    chk($sformatf("init_done@%0d", k), 32'(d), 32'(ed));
    chk($sformatf("busy@%0d", k), 32'(bs), 32'(!ed));
    is_cmd = (cm !== 4'b0111);
  endtask

  // Checks offsets 0..last_k; leaves the bench sampled at last_k.
  task automatic run_seq(input bit b, input int last_k, output int ncmd);
    bit ic;
    ncmd = 0;
    for (int k = 0; k <= last_k; k++) begin
      check_k(b, k, ic);
      if (ic) ncmd++;
      if (k < last_k) step();
    end
  endtask

  task automatic lock_up(input bit b);
    logic c, d, bs;
    logic [3:0] cm;
    logic [12:0] ad;
    logic [1:0] bb;
    if (b) pll_b = 1'b1; else pll_a = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      step();
      obs(b, c, cm, ad, bb, d, bs);
      chk($sformatf("cke_lock_edge%0d", e), 32'(c), 32'(0));
    end
    step();
  endtask

  task automatic pulse_restart();
    restart_a = 1'b1;
    step();
    restart_a = 1'b0;
  endtask

  initial begin
    int n, w, da, db;
    da = AP + ATRP + AR * ATRFC + ATMRD;
    db = BP + BT + BR * BT + BT;

    #1 rst_n = 1'b0;
    #1;
    check_idle(0, "rst_a");
    check_idle(1, "rst_b");
    repeat (3) step();
    rst_n = 1'b1;

    w = $urandom_range(6, 1);
    repeat (w) begin
      step();
      check_idle(0, "wait_lock");
    end

    lock_up(0);
    run_seq(0, da + 2, n);
    chk("cmd_count_first", 32'(n), 32'(AR + 2));

    pulse_restart();
    chk("restart_done_fall", 32'(done_a), 32'(0));
    chk("restart_cke_held", 32'(cke_a), 32'(1));
    run_seq(0, da + 1, n);
    chk("cmd_count_restart", 32'(n), 32'(AR + 2));

    w = $urandom_range(da - 1, 1);
    pulse_restart();
    run_seq(0, w, n);
    pulse_restart();
    run_seq(0, da + 1, n);
    chk("cmd_count_mid_restart", 32'(n), 32'(AR + 2));

    // Drop lock during the WAIT_TRFC that follows the second refresh.
    pulse_restart();
    run_seq(0, AP + ATRP + ATRFC + 1, n);
    pll_a = 1'b0;
    step();
    check_k(0, AP + ATRP + ATRFC + 2, n[0]);
    step();
    check_k(0, AP + ATRP + ATRFC + 3, n[0]);
    step();
    check_idle(0, "lock_loss");
    restart_a = 1'b1;
    step();
    restart_a = 1'b0;
    check_idle(0, "restart_in_wait_lock");
    step();
    check_idle(0, "restart_in_wait_lock2");
    lock_up(0);
    run_seq(0, da + 1, n);
    chk("cmd_count_relock", 32'(n), 32'(AR + 2));

    // Asynchronous reset in the middle of POWERUP.
    w = $urandom_range(AP - 2, 1);
    pulse_restart();
    run_seq(0, w, n);
    #3 rst_n = 1'b0;
    #1;
    check_idle(0, "async_rst");
    step();
    rst_n = 1'b1;
    lock_up(0);
    run_seq(0, da + 1, n);
    chk("cmd_count_after_rst", 32'(n), 32'(AR + 2));

    // Minimum timings: PRECHARGE, REFRESH, LOAD MODE back to back.
    w = $urandom_range(4, 1);
    repeat (w) step();
    check_idle(1, "b_wait_lock");
    lock_up(1);
    run_seq(1, db + 2, n);
    chk("cmd_count_min", 32'(n), 32'(BR + 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
